// File: rtl/mm2st_s2l_if.sv
// Bundles the control, RAM-read and Avalon-ST source signals of mm2st_s2l.
// The master modport is the streamer's view; slave is the view of whatever surrounds it.
interface mm2st_s2l_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              start;
  logic [9:0]        len;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mm_address;
  logic              mm_chipselect;
  logic              mm_clken;
  logic [15:0]       mm_readdata;
  logic [31:0]       st_data;
  logic              st_valid;
  logic              st_ready;
  logic              st_startofpacket;
  logic              st_endofpacket;
  logic [1:0]        st_empty;

  modport master (
    input  start, len, mm_readdata, st_ready,
    output busy, done, mm_address, mm_chipselect, mm_clken,
           st_data, st_valid, st_startofpacket, st_endofpacket, st_empty
  );

  modport slave (
    output start, len, mm_readdata, st_ready,
    input  busy, done, mm_address, mm_chipselect, mm_clken,
           st_data, st_valid, st_startofpacket, st_endofpacket, st_empty
  );
endinterface

// File: rtl/mm2st_s2l.sv
// Streams a 16-bit word RAM buffer out as an Avalon-ST packet, two words per 32-bit beat.
// Reads are throttled so the 4-word FIFO plus outstanding reads never exceed its depth.
module mm2st_s2l #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned MAX_LEN = 512
) (
  input  logic          clk,
  input  logic          rst,
  mm2st_s2l_if.master   bus
);

  localparam int unsigned PL_W  = ADDR_W + 1;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            r_state, w_state_n;
  logic [15:0]       r_mem [DEPTH];
  logic [1:0]        r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rd_v;
  logic              r_cs;
  logic [ADDR_W-1:0] r_mm_address;
  logic [ADDR_W-1:0] r_last;
  logic [PL_W-1:0]   r_pop_left;
  logic              r_first;
  logic [31:0]       r_st_data;
  logic              r_st_valid, r_st_sop, r_st_eop;
  logic [1:0]        r_st_empty;
  logic              r_busy, r_done;

  logic [31:0]       w_len_clip;
  logic              w_hs, w_eop_hs, w_take2, w_load, w_issue;
  logic [CNT_W-1:0]  w_pop, w_cnt_n;

  // Next-state, read issue and beat-load decisions.
  always_comb begin
    w_state_n  = r_state;
    w_issue    = 1'b0;
    w_len_clip = (32'(bus.len) > 32'(MAX_LEN)) ? 32'(MAX_LEN) : 32'(bus.len);
    w_hs       = r_st_valid && bus.st_ready;
    w_eop_hs   = w_hs && r_st_eop;
    w_take2    = (r_pop_left != PL_W'(1));
    w_load     = (!r_st_valid || bus.st_ready) && (r_pop_left != '0) &&
                 ((r_cnt >= CNT_W'(2)) || ((r_cnt != '0) && !w_take2));
    w_pop      = w_load ? (w_take2 ? CNT_W'(2) : CNT_W'(1)) : '0;
    w_cnt_n    = r_cnt + CNT_W'(r_rd_v) - w_pop;

    case (r_state)
      S_IDLE: begin
        if (bus.start && (bus.len != '0)) begin
          w_state_n = S_READ;
          w_issue   = 1'b1;
        end
      end
      S_READ: begin
        // mm_address only ever holds issued addresses, so reaching r_last means all reads are out
        if (r_mm_address == r_last) w_state_n = S_DRAIN;
        else if ((w_cnt_n + CNT_W'(r_cs)) < CNT_W'(DEPTH)) w_issue = 1'b1;
      end
      S_DRAIN: if (w_eop_hs) w_state_n = S_DONE;
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  // FIFO storage needs no reset; pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (r_rd_v) r_mem[r_wr_ptr] <= bus.mm_readdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_rd_v       <= 1'b0;
      r_cs         <= 1'b0;
      r_mm_address <= '0;
      r_last       <= '0;
      r_pop_left   <= '0;
      r_first      <= 1'b0;
      r_st_data    <= '0;
      r_st_valid   <= 1'b0;
      r_st_sop     <= 1'b0;
      r_st_eop     <= 1'b0;
      r_st_empty   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_busy <= (w_state_n != S_IDLE);
      r_done <= (r_state == S_DRAIN) && w_eop_hs;
      r_cs   <= w_issue;
      r_rd_v <= r_cs;
      if (w_issue)
        r_mm_address <= (r_state == S_IDLE) ? '0 : r_mm_address + ADDR_W'(1);
      if (r_rd_v) r_wr_ptr <= r_wr_ptr + 2'd1;
      r_rd_ptr <= r_rd_ptr + 2'(w_pop);
      r_cnt    <= w_cnt_n;

      if ((r_state == S_IDLE) && (w_state_n == S_READ)) begin
        r_last     <= ADDR_W'(w_len_clip - 32'd1);
        r_pop_left <= PL_W'(w_len_clip);
        r_first    <= 1'b1;
      end else if (w_load) begin
        r_pop_left <= r_pop_left - (w_take2 ? PL_W'(2) : PL_W'(1));
        r_first    <= 1'b0;
      end

      // A lone trailing word goes high with zero padding below it.
      if (w_load) begin
        r_st_data  <= w_take2 ? {r_mem[r_rd_ptr], r_mem[r_rd_ptr + 2'd1]}
                              : {r_mem[r_rd_ptr], 16'h0000};
        r_st_valid <= 1'b1;
        r_st_sop   <= r_first;
        r_st_eop   <= (r_pop_left <= PL_W'(2));
        r_st_empty <= w_take2 ? 2'd0 : 2'd2;
      end else if (w_hs) begin
        r_st_valid <= 1'b0;
        r_st_sop   <= 1'b0;
        r_st_eop   <= 1'b0;
        r_st_empty <= 2'd0;
      end
    end
  end

  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.mm_address       = r_mm_address;
  assign bus.mm_chipselect    = r_cs;
  assign bus.mm_clken         = r_cs;
  assign bus.st_data          = r_st_data;
  assign bus.st_valid         = r_st_valid;
  assign bus.st_startofpacket = r_st_sop;
  assign bus.st_endofpacket   = r_st_eop;
  assign bus.st_empty         = r_st_empty;

endmodule

// File: tb/tb_mm2st_s2l.sv
// Scoreboard bench for mm2st_s2l: expected beats are queued at start and
// popped by a negedge monitor as the sink accepts them.
module tb_mm2st_s2l;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned MAX_LEN = 512;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mm2st_s2l_if #(.ADDR_W(ADDR_W)) bus ();
  mm2st_s2l #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [15:0] ram [MAX_LEN];
  logic [15:0] ram_q;
  beat_t       exp_q [$];
  beat_t       cur_beat, prev_beat, exp_beat;
  bit          prev_stall = 1'b0;
  bit          rand_ready = 1'b0;
  int          checks = 0, failures = 0;
  int          done_cnt = 0, hs_cnt = 0, rd_idx = 0, max_addr = 0;

  // RAM model: data valid the cycle after a read is issued.
  always @(posedge clk) if (bus.mm_chipselect && bus.mm_clken) ram_q <= ram[bus.mm_address];
  assign bus.mm_readdata = ram_q;

  always @(posedge clk) begin
    #1;
    bus.st_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: read order, beat hold under backpressure, and scoreboard compare.
  always @(negedge clk) begin
    cur_beat = {bus.st_data, bus.st_startofpacket, bus.st_endofpacket, bus.st_empty};
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.done) done_cnt++;
      if (bus.mm_chipselect) begin
        checks++;
        if (bus.mm_address !== ADDR_W'(rd_idx) || bus.mm_clken !== 1'b1) begin
          failures++;
          $display("FAIL rd_addr got=%0d clken=%b exp=%0d", bus.mm_address, bus.mm_clken, rd_idx);
        end
        if (int'(bus.mm_address) > max_addr) max_addr = int'(bus.mm_address);
        rd_idx++;
      end
      if (prev_stall) begin
        checks++;
        if (bus.st_valid !== 1'b1 || cur_beat !== prev_beat) begin
          failures++;
          $display("FAIL hold got=%h v=%b exp=%h", cur_beat, bus.st_valid, prev_beat);
        end
      end
      if (bus.st_valid && bus.st_ready) begin
        checks++;
        hs_cnt++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_beat got=%h exp=none", cur_beat);
        end else begin
          exp_beat = exp_q.pop_front();
          if (cur_beat !== exp_beat) begin
            failures++;
            $display("FAIL beat got=%h exp=%h", cur_beat, exp_beat);
          end
        end
      end
      prev_stall = bus.st_valid && !bus.st_ready;
      prev_beat  = cur_beat;
    end
  end

  function automatic logic [ADDR_W+40:0] outs();
    return {bus.busy, bus.done, bus.mm_address, bus.mm_chipselect, bus.mm_clken, bus.st_data,
            bus.st_valid, bus.st_startofpacket, bus.st_endofpacket, bus.st_empty};
  endfunction

  // Queue the expected beats for a packet, then pulse start for one cycle.
  task automatic start_pkt(input int n);
    int eff;
    int nb;
    logic [15:0] lo;
    eff = (n > int'(MAX_LEN)) ? int'(MAX_LEN) : n;
    nb  = (eff + 1) / 2;
    rd_idx = 0;
    for (int b = 0; b < nb; b++) begin
      lo = (2 * b + 1 < eff) ? ram[2 * b + 1] : 16'h0000;
      exp_q.push_back({ram[2 * b], lo, (b == 0), (b == nb - 1),
                       (2 * b + 1 < eff) ? 2'd0 : 2'd2});
    end
    bus.len   = 10'(n);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.len   = '0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (outs() !== '0) begin
      failures++;
      $display("FAIL reset_outs got=%h exp=0", outs());
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_len4();
    int k, d0;
    bit ok;
    d0 = done_cnt; max_addr = 0;
    start_pkt(4);
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_after_start got=%b exp=1", bus.busy); end
    k = 1;
    while (!bus.st_valid && k < 20) begin @(negedge clk); k++; end
    checks++;
    if (k - 1 != 4) begin failures++; $display("FAIL first_valid_latency got=%0d exp=4", k - 1); end
    wait_idle(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL len4_timeout got=busy exp=idle"); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL len4_missing got=%0d exp=0", exp_q.size()); end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL len4_done got=%0d exp=1", done_cnt - d0); end
    checks++;
    if (max_addr != 3) begin failures++; $display("FAIL len4_maxaddr got=%0d exp=3", max_addr); end
  endtask

  task automatic test_odd();
    int d0;
    bit ok;
    for (int t = 0; t < 2; t++) begin
      d0 = done_cnt;
      start_pkt(t == 0 ? 3 : 1);
      wait_idle(100, ok);
      checks++;
      if (!ok || exp_q.size() != 0) begin
        failures++;
        $display("FAIL odd_len%0d got=ok%b left%0d exp=ok1 left0", t == 0 ? 3 : 1, ok, exp_q.size());
      end
      checks++;
      if (done_cnt - d0 != 1) begin failures++; $display("FAIL odd_done got=%0d exp=1", done_cnt - d0); end
    end
  endtask

  task automatic test_clip();
    int d0;
    bit ok;
    d0 = done_cnt; max_addr = 0;
    start_pkt(700);
    wait_idle(2000, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL clip got=ok%b left%0d exp=ok1 left0", ok, exp_q.size());
    end
    checks++;
    if (max_addr != 511) begin failures++; $display("FAIL clip_maxaddr got=%0d exp=511", max_addr); end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL clip_done got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_backpressure();
    int d0, h0;
    bit ok;
    for (int i = 0; i < int'(MAX_LEN); i++) ram[i] = 16'($urandom);
    d0 = done_cnt; max_addr = 0; h0 = hs_cnt;
    rand_ready = 1'b1;
    start_pkt(512);
    wait_idle(5000, ok);
    rand_ready = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_timeout got=busy exp=idle"); end
    checks++;
    if (hs_cnt - h0 != 256 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_beats got=%0d left%0d exp=256 left0", hs_cnt - h0, exp_q.size());
    end
    checks++;
    if (max_addr != 511) begin failures++; $display("FAIL bp_maxaddr got=%0d exp=511", max_addr); end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL bp_done got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_ignore();
    int d0;
    bit ok, bad;
    for (int i = 0; i < 4; i++) ram[i] = 16'((i + 1) * 16'h1111);
    d0 = done_cnt; bad = 1'b0;
    bus.len = '0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy || bus.mm_chipselect || bus.st_valid) bad = 1'b1;
    end
    checks++;
    if (bad || done_cnt != d0) begin failures++; $display("FAIL len0_start got=active exp=idle"); end
    start_pkt(4);
    @(negedge clk);
    bus.len = 10'd2; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(100, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL busy_start got=ok%b left%0d exp=ok1 left0", ok, exp_q.size());
    end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL busy_start_done got=%0d exp=1", done_cnt - d0); end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL busy_start_restart got=busy%b done%0d exp=busy0 done1", bus.busy, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d0, h0, k;
    bit ok, bad;
    d0 = done_cnt;
    start_pkt(8);
    h0 = hs_cnt; k = 0;
    while (hs_cnt - h0 < 2 && k < 100) begin @(negedge clk); k++; end
    checks++;
    if (k >= 100) begin failures++; $display("FAIL mid_wait got=%0d beats exp=2", hs_cnt - h0); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (outs() !== '0) begin failures++; $display("FAIL mid_reset_outs got=%h exp=0", outs()); end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.st_valid || bus.mm_chipselect || bus.busy) bad = 1'b1;
    end
    checks++;
    if (bad || done_cnt != d0) begin
      failures++;
      $display("FAIL mid_abort got=active%b done%0d exp=active0 done%0d", bad, done_cnt, d0);
    end
    start_pkt(2);
    wait_idle(100, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++;
      $display("FAIL after_reset got=ok%b left%0d exp=ok1 left0", ok, exp_q.size());
    end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL after_reset_done got=%0d exp=1", done_cnt - d0); end
  endtask

  initial begin
    for (int i = 0; i < int'(MAX_LEN); i++) ram[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) ram[i] = 16'((i + 1) * 16'h1111);
    test_reset();
    test_len4();
    test_odd();
    test_ignore();
    test_reset_mid();
    test_clip();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
